// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order commit reorder buffer with CDB capture and operand bypass
module reorder_buffer #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 flushIn,
  input  logic                 issueValid,
  input  logic [4:0]           issueDest,
  input  logic                 issueReady,
  input  logic [31:0]          issueValue,
  output logic [ROB_WIDTH-1:0] issueRobId,
  output logic                 robFull,
  input  logic                 cdbValid,
  input  logic [ROB_WIDTH-1:0] cdbRobId,
  input  logic [31:0]          cdbValue,
  input  logic [ROB_WIDTH-1:0] robRs1Dep,
  input  logic [ROB_WIDTH-1:0] robRs2Dep,
  output logic                 robRs1Ready,
  output logic                 robRs2Ready,
  output logic [31:0]          robRs1Value,
  output logic [31:0]          robRs2Value,
  output logic                 regUpdateValid,
  output logic [4:0]           regUpdateDest,
  output logic [31:0]          regUpdateValue,
  output logic [ROB_WIDTH-1:0] regUpdateRobId
);

  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0]   FULL_COUNT = (ROB_WIDTH + 1)'(DEPTH);
  localparam logic [ROB_WIDTH:0]   CNT_ONE    = (ROB_WIDTH + 1)'(1);
  localparam logic [ROB_WIDTH-1:0] ID_ONE     = ROB_WIDTH'(1);

  logic [DEPTH-1:0]     busy;
  logic [DEPTH-1:0]     ready;
  logic [4:0]           dest  [DEPTH];
  logic [31:0]          value [DEPTH];
  logic [ROB_WIDTH-1:0] head;
  logic [ROB_WIDTH-1:0] tail;
  logic [ROB_WIDTH:0]   count;
  logic                 issueAccept;
  logic                 cdbHit;
  logic                 commitFire;

  assign robFull     = (count == FULL_COUNT);
  assign issueRobId  = tail;
  assign issueAccept = issueValid && !robFull;
  assign cdbHit      = cdbValid && busy[cdbRobId];
  // Commit looks only at the registered ready bit, so a same-cycle CDB completion commits one cycle later.
  assign commitFire  = (count != '0) && busy[head] && ready[head];

  always_comb begin
    robRs1Ready = busy[robRs1Dep] && ready[robRs1Dep];
    robRs1Value = value[robRs1Dep];
    robRs2Ready = busy[robRs2Dep] && ready[robRs2Dep];
    robRs2Value = value[robRs2Dep];
    if (cdbValid && (cdbRobId == robRs1Dep)) begin
      robRs1Ready = 1'b1;
      robRs1Value = cdbValue;
    end
    if (cdbValid && (cdbRobId == robRs2Dep)) begin
      robRs2Ready = 1'b1;
      robRs2Value = cdbValue;
    end
  end

  // Payload needs no reset: busy gates every read of it.
  always_ff @(posedge clockIn) begin
    if (issueAccept) begin
      dest[tail]  <= issueDest;
      value[tail] <= issueValue;
    end
    if (cdbHit) begin
      value[cdbRobId] <= cdbValue;
    end
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      busy           <= '0;
      ready          <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      regUpdateValid <= 1'b0;
      regUpdateDest  <= '0;
      regUpdateValue <= '0;
      regUpdateRobId <= '0;
    end else if (flushIn) begin
      busy           <= '0;
      ready          <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      regUpdateValid <= 1'b0;
    end else begin
      regUpdateValid <= commitFire;
      if (commitFire) begin
        regUpdateDest  <= dest[head];
        regUpdateValue <= value[head];
        regUpdateRobId <= head;
        busy[head]     <= 1'b0;
        head           <= head + ID_ONE;
      end
      if (cdbHit) begin
        ready[cdbRobId] <= 1'b1;
      end
      // Tail never aliases a busy entry when not full, so issue cannot collide with commit or CDB.
      if (issueAccept) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= issueReady;
        tail        <= tail + ID_ONE;
      end
      case ({issueAccept, commitFire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer
module tb_reorder_buffer;

  localparam int W = 4;
  localparam int D = 16;

  logic         clockIn = 1'b0;
  logic         resetIn = 1'b0;
  logic         flushIn = 1'b0;
  logic         issueValid = 1'b0;
  logic [4:0]   issueDest = '0;
  logic         issueReady = 1'b0;
  logic [31:0]  issueValue = '0;
  logic [W-1:0] issueRobId;
  logic         robFull;
  logic         cdbValid = 1'b0;
  logic [W-1:0] cdbRobId = '0;
  logic [31:0]  cdbValue = '0;
  logic [W-1:0] robRs1Dep = '0;
  logic [W-1:0] robRs2Dep = '0;
  logic         robRs1Ready, robRs2Ready;
  logic [31:0]  robRs1Value, robRs2Value;
  logic         regUpdateValid;
  logic [4:0]   regUpdateDest;
  logic [31:0]  regUpdateValue;
  logic [W-1:0] regUpdateRobId;

  reorder_buffer #(.ROB_WIDTH(W)) dut (
    .clockIn(clockIn), .resetIn(resetIn), .flushIn(flushIn),
    .issueValid(issueValid), .issueDest(issueDest), .issueReady(issueReady),
    .issueValue(issueValue), .issueRobId(issueRobId), .robFull(robFull),
    .cdbValid(cdbValid), .cdbRobId(cdbRobId), .cdbValue(cdbValue),
    .robRs1Dep(robRs1Dep), .robRs2Dep(robRs2Dep),
    .robRs1Ready(robRs1Ready), .robRs2Ready(robRs2Ready),
    .robRs1Value(robRs1Value), .robRs2Value(robRs2Value),
    .regUpdateValid(regUpdateValid), .regUpdateDest(regUpdateDest),
    .regUpdateValue(regUpdateValue), .regUpdateRobId(regUpdateRobId)
  );

  always #5 clockIn = ~clockIn;

  // Reference model: in-flight instructions held oldest-first in a queue.
  typedef struct {
    logic [W-1:0] id;
    logic [4:0]   dest;
    bit           rdy;
    logic [31:0]  val;
  } ent_t;

  ent_t         mq[$];
  int           mtail;
  bit           e_uv;
  logic [4:0]   e_ud;
  logic [31:0]  e_uval;
  logic [W-1:0] e_uid;
  int           n_checks = 0;
  int           n_fail = 0;

  typedef struct {
    bit iv; logic [4:0] idst; bit ir; logic [31:0] ival;
    bit cv; logic [W-1:0] cid; logic [31:0] cval; bit fl;
    bit euv; logic [4:0] eud; logic [31:0] euval; logic [W-1:0] euid; int ecnt;
  } vec_t;

  vec_t vt[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mtail = 0;
    e_uv = 0; e_ud = '0; e_uval = '0; e_uid = '0;
  endtask

  task automatic model_query(input logic [W-1:0] dep, output bit rdy, output logic [31:0] val);
    rdy = 0;
    val = '0;
    if (cdbValid && cdbRobId == dep) begin
      rdy = 1; val = cdbValue;
    end else begin
      foreach (mq[i]) if (mq[i].id == dep && mq[i].rdy) begin
        rdy = 1; val = mq[i].val;
      end
    end
  endtask

  task automatic model_clock();
    if (flushIn) begin
      mq.delete();
      mtail = 0;
      e_uv = 0;
    end else begin
      bit   full;
      bit   commit;
      ent_t hd;
      ent_t ne;
      full = (mq.size() == D);
      commit = (mq.size() > 0) && mq[0].rdy;
      if (commit) hd = mq[0];
      if (cdbValid) foreach (mq[i]) if (mq[i].id == cdbRobId) begin
        mq[i].rdy = 1; mq[i].val = cdbValue;
      end
      e_uv = commit;
      if (commit) begin
        e_ud = hd.dest; e_uval = hd.val; e_uid = hd.id;
        void'(mq.pop_front());
      end
      if (issueValid && !full) begin
        ne.id = W'(mtail); ne.dest = issueDest; ne.rdy = issueReady; ne.val = issueValue;
        mq.push_back(ne);
        mtail = (mtail + 1) % D;
      end
    end
  endtask

  task automatic step();
    bit          r;
    logic [31:0] v;
    #1;
    chk("robFull", robFull, mq.size() == D);
    chk("issueRobId", issueRobId, mtail);
    model_query(robRs1Dep, r, v);
    chk("rs1Ready", robRs1Ready, r);
    if (r) chk("rs1Value", robRs1Value, v);
    model_query(robRs2Dep, r, v);
    chk("rs2Ready", robRs2Ready, r);
    if (r) chk("rs2Value", robRs2Value, v);
    @(posedge clockIn);
    model_clock();
    #1;
    chk("regUpdateValid", regUpdateValid, e_uv);
    chk("regUpdateDest", regUpdateDest, e_ud);
    chk("regUpdateValue", regUpdateValue, e_uval);
    chk("regUpdateRobId", regUpdateRobId, e_uid);
    chk("count", dut.count, mq.size());
  endtask

  task automatic set_in(input bit iv, input logic [4:0] idst, input bit ir, input logic [31:0] ival,
                        input bit cv, input logic [W-1:0] cid, input logic [31:0] cval, input bit fl);
    issueValid = iv; issueDest = idst; issueReady = ir; issueValue = ival;
    cdbValid = cv; cdbRobId = cid; cdbValue = cval; flushIn = fl;
    robRs1Dep = W'($urandom_range(D - 1));
    robRs2Dep = W'($urandom_range(D - 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{1, 5, 1, 'h11, 0, 0, 0,     0, 0, 0, 0,     0, 1};
    vt[1]  = '{0, 0, 0, 0,    0, 0, 0,     0, 1, 5, 'h11,  0, 0};
    vt[2]  = '{0, 0, 0, 0,    0, 0, 0,     0, 0, 0, 0,     0, 0};
    vt[3]  = '{1, 7, 0, 0,    0, 0, 0,     0, 0, 0, 0,     0, 1};
    vt[4]  = '{1, 8, 0, 0,    0, 0, 0,     0, 0, 0, 0,     0, 2};
    vt[5]  = '{0, 0, 0, 0,    1, 2, 'h22,  0, 0, 0, 0,     0, 2};
    vt[6]  = '{0, 0, 0, 0,    1, 1, 'h21,  0, 0, 0, 0,     0, 2};
    vt[7]  = '{0, 0, 0, 0,    0, 0, 0,     0, 1, 7, 'h21,  1, 1};
    vt[8]  = '{0, 0, 0, 0,    0, 0, 0,     0, 1, 8, 'h22,  2, 0};
    vt[9]  = '{0, 0, 0, 0,    0, 0, 0,     0, 0, 0, 0,     0, 0};
    vt[10] = '{1, 0, 1, 'h33, 0, 0, 0,     0, 0, 0, 0,     0, 1};
    vt[11] = '{1, 9, 1, 'h44, 0, 0, 0,     0, 1, 0, 'h33,  3, 1};
    vt[12] = '{0, 0, 0, 0,    0, 0, 0,     0, 1, 9, 'h44,  4, 0};
    vt[13] = '{1, 1, 0, 0,    0, 0, 0,     0, 0, 0, 0,     0, 1};
    vt[14] = '{1, 2, 0, 0,    0, 0, 0,     0, 0, 0, 0,     0, 2};
    vt[15] = '{1, 3, 1, 'h66, 0, 0, 0,     0, 0, 0, 0,     0, 3};
    vt[16] = '{1, 4, 1, 'h99, 1, 5, 'h55,  1, 0, 0, 0,     0, 0};
    vt[17] = '{0, 0, 0, 0,    0, 0, 0,     0, 0, 0, 0,     0, 0};
    vt[18] = '{1, 4, 1, 'h77, 0, 0, 0,     0, 0, 0, 0,     0, 1};
    vt[19] = '{0, 0, 0, 0,    0, 0, 0,     0, 1, 4, 'h77,  0, 0};

    model_reset();
    #1;
    chk("reset regUpdateValid", regUpdateValid, 0);
    chk("reset robFull", robFull, 0);
    chk("reset issueRobId", issueRobId, 0);
    repeat (2) @(posedge clockIn);
    #1;
    resetIn = 1'b1;

    foreach (vt[k]) begin
      set_in(vt[k].iv, vt[k].idst, vt[k].ir, vt[k].ival, vt[k].cv, vt[k].cid, vt[k].cval, vt[k].fl);
      step();
      chk($sformatf("vec%0d uv", k), regUpdateValid, vt[k].euv);
      chk($sformatf("vec%0d count", k), dut.count, vt[k].ecnt);
      if (vt[k].euv) begin
        chk($sformatf("vec%0d dest", k), regUpdateDest, vt[k].eud);
        chk($sformatf("vec%0d value", k), regUpdateValue, vt[k].euval);
        chk($sformatf("vec%0d id", k), regUpdateRobId, vt[k].euid);
      end
    end

    // Same-cycle CDB bypass on a query
    set_in(0, 0, 0, 0, 1, 3, 'hABCD, 0);
    robRs1Dep = 3;
    #1;
    chk("bypass rs1Ready", robRs1Ready, 1);
    chk("bypass rs1Value", robRs1Value, 'hABCD);
    step();

    // Asynchronous reset right after a commit pulse
    set_in(1, 3, 1, 'h5A, 0, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("pre-reset pulse", regUpdateValid, 1);
    resetIn = 1'b0;
    #2;
    model_reset();
    chk("async regUpdateValid", regUpdateValid, 0);
    chk("async regUpdateDest", regUpdateDest, 0);
    chk("async regUpdateValue", regUpdateValue, 0);
    chk("async regUpdateRobId", regUpdateRobId, 0);
    chk("async issueRobId", issueRobId, 0);
    chk("async count", dut.count, 0);
    resetIn = 1'b1;

    // Fill to full, overflow attempt, then commit with a rejected issue
    for (int i = 0; i < D; i++) begin
      set_in(1, 5'(i + 1), 0, 32'(i), 0, 0, 0, 0);
      step();
    end
    chk("full robFull", robFull, 1);
    chk("full tail wrap", issueRobId, 0);
    set_in(1, 30, 1, 'hDEAD, 0, 0, 0, 0);
    step();
    chk("17th ignored count", dut.count, 16);
    set_in(1, 30, 1, 'hDEAD, 1, 0, 'hC0, 0);
    step();
    chk("cdb while full count", dut.count, 16);
    set_in(1, 30, 1, 'hDEAD, 0, 0, 0, 0);
    step();
    chk("full commit+issue count", dut.count, 15);
    chk("full commit id", regUpdateRobId, 0);
    chk("full commit value", regUpdateValue, 'hC0);
    chk("robFull cleared", robFull, 0);
    set_in(0, 0, 0, 0, 1, 1, 'hC1, 0);
    step();
    set_in(1, 31, 0, 'hBEEF, 0, 0, 0, 0);
    step();
    chk("commit+issue count", dut.count, 15);
    chk("commit+issue id", regUpdateRobId, 1);

    // Randomized traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] cid;
      cid = W'($urandom_range(D - 1));
      if (mq.size() > 0 && ($urandom % 4) != 0) cid = mq[$urandom_range(mq.size() - 1)].id;
      set_in(($urandom % 4) != 0, 5'($urandom), ($urandom % 3) == 0, $urandom,
             ($urandom % 2) == 0, cid, $urandom, ($urandom % 200) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
